// File: rtl/vdma_rd_frame_requester_if.sv
// Read-scheduler client slot: burst request and address/size towards the scheduler,
// with ack, done and data-valid strobes coming back.
interface vdma_rd_frame_requester_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  logic                      req_o;
  logic [AXI_ADDR_WIDTH-1:0] rstart_addr_o;
  logic [7:0]                burst_size_o;
  logic                      ack_i;
  logic                      done_i;
  logic                      data_valid_i;

  modport master (output req_o, rstart_addr_o, burst_size_o,
                  input  ack_i, done_i, data_valid_i);
  modport slave  (input  req_o, rstart_addr_o, burst_size_o,
                  output ack_i, done_i, data_valid_i);
endinterface

// File: rtl/vdma_rd_frame_requester.sv
// VDMA read-path frame requester: walks a frame line by line and issues one burst at a time.
// Optional beat-count checking is enabled by defining VDMA_RD_BEAT_CHECK_EN.
module vdma_rd_frame_requester #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int BYTES_PER_BEAT = 8,
  parameter int HRES_WIDTH     = 16,
  parameter int VRES_WIDTH     = 16
) (
  input  logic                      sys_clk_i,
  input  logic                      reset_i,
  input  logic                      frame_start_i,
  input  logic [AXI_ADDR_WIDTH-1:0] frame_base_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0] line_stride_i,
  input  logic [HRES_WIDTH-1:0]     hres_beats_i,
  input  logic [VRES_WIDTH-1:0]     vres_i,
  input  logic [7:0]                max_burst_i,
  input  logic [HRES_WIDTH-1:0]     fifo_space_i,
  vdma_rd_frame_requester_if.master sched,
  output logic                      busy_o,
  output logic                      line_done_o,
  output logic                      frame_done_o,
  output logic                      error_o
);

  // len can reach 256, so keep at least 9 bits for it regardless of HRES_WIDTH
  localparam int LW         = (HRES_WIDTH > 9) ? HRES_WIDTH : 9;
  localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    WAIT_SPACE = 3'd2,
    REQ        = 3'd3,
    WAIT_DONE  = 3'd4,
    LINE_END   = 3'd5
  } state_t;

  state_t                    state_r;
  logic [AXI_ADDR_WIDTH-1:0] stride_r;
  logic [AXI_ADDR_WIDTH-1:0] line_start_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [HRES_WIDTH-1:0]     hres_r;
  logic [HRES_WIDTH-1:0]     remaining_r;
  logic [VRES_WIDTH-1:0]     vres_r;
  logic [VRES_WIDTH-1:0]     line_cnt_r;
  logic [7:0]                max_burst_r;
  logic [LW-1:0]             len_r;

  logic [LW-1:0]             cap_s;
  logic [LW-1:0]             len_s;
  logic                      space_ok_s;
  logic [AXI_ADDR_WIDTH-1:0] step_s;
  logic                      last_burst_s;
  logic                      last_line_s;
  logic                      start_ok_s;
  logic                      done_evt_s;

  // Burst sizing, completion and frame-accept decode
  always_comb begin
    cap_s        = LW'(max_burst_r) + LW'(1'b1);
    len_s        = (LW'(remaining_r) < cap_s) ? LW'(remaining_r) : cap_s;
    space_ok_s   = (LW'(fifo_space_i) >= len_s);
    step_s       = AXI_ADDR_WIDTH'(len_r) << BEAT_SHIFT;
    last_burst_s = (LW'(remaining_r) == len_r);
    last_line_s  = ((line_cnt_r + VRES_WIDTH'(1'b1)) == vres_r);
    start_ok_s   = frame_start_i && (hres_beats_i != HRES_WIDTH'(1'b0)) &&
                   (vres_i != VRES_WIDTH'(1'b0));
    // ack and done in the same REQ cycle complete the burst directly
    done_evt_s   = sched.done_i && ((state_r == WAIT_DONE) ||
                                    ((state_r == REQ) && sched.ack_i));
  end

  // Frame/line/burst sequencer with registered outputs
  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r             <= IDLE;
      stride_r            <= '0;
      line_start_r        <= '0;
      addr_r              <= '0;
      hres_r              <= '0;
      remaining_r         <= '0;
      vres_r              <= '0;
      line_cnt_r          <= '0;
      max_burst_r         <= 8'd0;
      len_r               <= '0;
      sched.req_o         <= 1'b0;
      sched.rstart_addr_o <= '0;
      sched.burst_size_o  <= 8'd0;
      busy_o              <= 1'b0;
      line_done_o         <= 1'b0;
      frame_done_o        <= 1'b0;
    end else begin
      line_done_o  <= 1'b0;
      frame_done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            stride_r     <= line_stride_i;
            line_start_r <= frame_base_addr_i;
            hres_r       <= hres_beats_i;
            vres_r       <= vres_i;
            max_burst_r  <= max_burst_i;
            line_cnt_r   <= '0;
            busy_o       <= 1'b1;
            state_r      <= SETUP;
          end
        end
        SETUP: begin
          addr_r      <= line_start_r;
          remaining_r <= hres_r;
          state_r     <= WAIT_SPACE;
        end
        WAIT_SPACE: begin
          if (space_ok_s) begin
            len_r               <= len_s;
            sched.rstart_addr_o <= addr_r;
            sched.burst_size_o  <= 8'(len_s - LW'(1'b1));
            sched.req_o         <= 1'b1;
            state_r             <= REQ;
          end
        end
        REQ: begin
          if (sched.ack_i) begin
            sched.req_o <= 1'b0;
            state_r     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          state_r <= WAIT_DONE;
        end
        LINE_END: begin
          line_cnt_r <= line_cnt_r + VRES_WIDTH'(1'b1);
          if (last_line_s) begin
            busy_o  <= 1'b0;
            state_r <= IDLE;
          end else begin
            line_start_r <= line_start_r + stride_r;
            state_r      <= SETUP;
          end
        end
        default: begin
          sched.req_o <= 1'b0;
          busy_o      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase

      // Completion overrides the per-state next state chosen above
      if (done_evt_s) begin
        addr_r      <= addr_r + step_s;
        remaining_r <= remaining_r - HRES_WIDTH'(len_r);
        if (last_burst_s) begin
          line_done_o  <= 1'b1;
          frame_done_o <= last_line_s;
          state_r      <= LINE_END;
        end else begin
          state_r <= WAIT_SPACE;
        end
      end
    end
  end

`ifdef VDMA_RD_BEAT_CHECK_EN
  logic [8:0] beat_cnt_r;
  logic [8:0] beat_cnt_s;

  // Beat count including a beat arriving in the current cycle
  always_comb begin
    beat_cnt_s = (sched.ack_i ? 9'd0 : beat_cnt_r) + 9'(sched.data_valid_i);
  end

  // Beat counter and sticky error, cleared by an accepted frame start
  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      beat_cnt_r <= 9'd0;
      error_o    <= 1'b0;
    end else begin
      beat_cnt_r <= beat_cnt_s;
      if ((state_r == IDLE) && start_ok_s) begin
        error_o <= 1'b0;
      end else if (done_evt_s && (beat_cnt_s != (9'(sched.burst_size_o) + 9'd1))) begin
        error_o <= 1'b1;
      end
    end
  end
`else
  logic unused_data_valid_s;
  assign unused_data_valid_s = sched.data_valid_i;
  assign error_o             = 1'b0;
`endif

endmodule

// File: tb/tb_vdma_rd_frame_requester.sv
// Directed self-checking bench for vdma_rd_frame_requester with a hand-driven scheduler slot.
module tb_vdma_rd_frame_requester;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [31:0] base;
  logic [31:0] stride;
  logic [15:0] hres;
  logic [15:0] vres;
  logic [7:0]  max_burst;
  logic [15:0] space;
  logic        busy;
  logic        line_done;
  logic        frame_done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  vdma_rd_frame_requester_if #(.AXI_ADDR_WIDTH(32)) sched_if ();

  vdma_rd_frame_requester dut (
    .sys_clk_i         (clk),
    .reset_i           (rst_n),
    .frame_start_i     (frame_start),
    .frame_base_addr_i (base),
    .line_stride_i     (stride),
    .hres_beats_i      (hres),
    .vres_i            (vres),
    .max_burst_i       (max_burst),
    .fifo_space_i      (space),
    .sched             (sched_if),
    .busy_o            (busy),
    .line_done_o       (line_done),
    .frame_done_o      (frame_done),
    .error_o           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] h,
                       input logic [15:0] v, input logic [7:0] m);
    base = b; stride = s; hres = h; vres = v; max_burst = m;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Wait for a request, check it, then ack and complete it
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [7:0] exp_size,
                       input int ack_dly, input int beats, input bit same);
    int t = 0;
    while (!sched_if.req_o && t < 50) begin
      step();
      t++;
    end
    chk({tag, "_req"}, 32'(sched_if.req_o), 32'd1);
    chk({tag, "_addr"}, sched_if.rstart_addr_o, exp_addr);
    chk({tag, "_size"}, 32'(sched_if.burst_size_o), 32'(exp_size));
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk({tag, "_hold_req"}, 32'(sched_if.req_o), 32'd1);
      chk({tag, "_hold_addr"}, sched_if.rstart_addr_o, exp_addr);
      chk({tag, "_hold_size"}, 32'(sched_if.burst_size_o), 32'(exp_size));
    end
    if (same) begin
      sched_if.ack_i = 1'b1; sched_if.done_i = 1'b1; sched_if.data_valid_i = (beats > 0);
      step();
      sched_if.ack_i = 1'b0; sched_if.done_i = 1'b0; sched_if.data_valid_i = 1'b0;
    end else begin
      sched_if.ack_i = 1'b1;
      step();
      sched_if.ack_i = 1'b0;
      chk({tag, "_req_fall"}, 32'(sched_if.req_o), 32'd0);
      for (int i = 0; i < beats; i++) begin
        sched_if.data_valid_i = 1'b1;
        step();
      end
      sched_if.data_valid_i = 1'b0;
      sched_if.done_i = 1'b1;
      step();
      sched_if.done_i = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; base = 32'd0; stride = 32'd0;
    hres = 16'd0; vres = 16'd0; max_burst = 8'd0; space = 16'd1024;
    sched_if.ack_i = 1'b0; sched_if.done_i = 1'b0; sched_if.data_valid_i = 1'b0;
    step(); step();
    chk("rst_req", 32'(sched_if.req_o), 32'd0);
    chk("rst_addr", sched_if.rstart_addr_o, 32'd0);
    chk("rst_size", 32'(sched_if.burst_size_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", {30'd0, line_done, frame_done}, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    step();

    // Two-line frame, bursts 16/16/8 per line
    start(32'h1000, 32'h800, 16'd40, 16'd2, 8'd15);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_req_n1", 32'(sched_if.req_o), 32'd0);
    step();
    chk("t1_req_n2", 32'(sched_if.req_o), 32'd0);
    step();
    chk("t1_req_n3", 32'(sched_if.req_o), 32'd1);
    serve("t1_b0", 32'h1000, 8'd15, 0, 16, 1'b0);
    chk("t1_req_after_done", 32'(sched_if.req_o), 32'd0);
    chk("t1_no_line_done", 32'(line_done), 32'd0);
    step();
    chk("t1_req_2cyc", 32'(sched_if.req_o), 32'd1);
    serve("t1_b1", 32'h1080, 8'd15, 0, 16, 1'b0);
    serve("t1_b2", 32'h1100, 8'd7, 0, 8, 1'b0);
    chk("t1_line0_done", 32'(line_done), 32'd1);
    chk("t1_line0_nofd", 32'(frame_done), 32'd0);
    serve("t1_b3", 32'h1800, 8'd15, 0, 16, 1'b0);
    serve("t1_b4", 32'h1880, 8'd15, 0, 16, 1'b0);
    serve("t1_b5", 32'h1900, 8'd7, 0, 8, 1'b0);
    chk("t1_line1_done", 32'(line_done), 32'd1);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    chk("t1_busy_at_fd", 32'(busy), 32'd1);
    step();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_pulses_clear", {30'd0, line_done, frame_done}, 32'd0);
    chk("t1_error", 32'(error), 32'd0);

    // Insufficient FIFO space holds off the request; then a slow ack
    space = 16'd10;
    start(32'h2000, 32'h800, 16'd40, 16'd1, 8'd15);
    for (int i = 0; i < 5; i++) step();
    chk("t2_req_blocked", 32'(sched_if.req_o), 32'd0);
    space = 16'd16;
    step(); step();
    chk("t2_req_rise", 32'(sched_if.req_o), 32'd1);
    serve("t3_b0", 32'h2000, 8'd15, 5, 16, 1'b0);
    serve("t3_b1", 32'h2080, 8'd15, 0, 16, 1'b0);
    serve("t3_b2", 32'h2100, 8'd7, 0, 8, 1'b0);
    chk("t3_frame_done", 32'(frame_done), 32'd1);
    space = 16'd1024;
    step();

    // 1-beat lines with ack and done in the same cycle
    start(32'h3000, 32'h40, 16'd1, 16'd2, 8'd15);
    serve("t4_l0", 32'h3000, 8'd0, 0, 1, 1'b1);
    chk("t4_l0_line_done", 32'(line_done), 32'd1);
    chk("t4_l0_nofd", 32'(frame_done), 32'd0);
    serve("t4_l1", 32'h3040, 8'd0, 0, 1, 1'b1);
    chk("t4_l1_frame_done", 32'(frame_done), 32'd1);
    step();

    // Reset while burst 2 is outstanding, then restart from a new base
    start(32'h4000, 32'h800, 16'd40, 16'd1, 8'd15);
    serve("t5_b0", 32'h4000, 8'd15, 0, 16, 1'b0);
    step();
    chk("t5_b1_req", 32'(sched_if.req_o), 32'd1);
    chk("t5_b1_addr", sched_if.rstart_addr_o, 32'h4080);
    sched_if.ack_i = 1'b1;
    step();
    sched_if.ack_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(sched_if.req_o), 32'd0);
    chk("t5_rst_addr", sched_if.rstart_addr_o, 32'd0);
    chk("t5_rst_size", 32'(sched_if.burst_size_o), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start(32'h5000, 32'h100, 16'd8, 16'd1, 8'd15);
    serve("t5_new", 32'h5000, 8'd7, 0, 8, 1'b0);
    chk("t5_new_fd", 32'(frame_done), 32'd1);
    step();

    // Zero-sized frames are ignored
    start(32'h6000, 32'h100, 16'd8, 16'd0, 8'd7);
    chk("t6_vres0_busy", 32'(busy), 32'd0);
    start(32'h6000, 32'h100, 16'd0, 16'd4, 8'd7);
    chk("t6_hres0_busy", 32'(busy), 32'd0);
    step(); step(); step();
    chk("t6_no_req", 32'(sched_if.req_o), 32'd0);

`ifdef VDMA_RD_BEAT_CHECK_EN
    // Short burst flags an error that the next frame start clears
    start(32'h7000, 32'h100, 16'd8, 16'd1, 8'd7);
    serve("t7_short", 32'h7000, 8'd7, 0, 7, 1'b0);
    chk("t7_error_set", 32'(error), 32'd1);
    step();
    chk("t7_error_sticky", 32'(error), 32'd1);
    start(32'h7000, 32'h100, 16'd8, 16'd1, 8'd7);
    chk("t7_error_clear", 32'(error), 32'd0);
    serve("t7_full", 32'h7000, 8'd7, 0, 8, 1'b0);
    chk("t7_error_ok", 32'(error), 32'd0);
`else
    chk("t7_error_tied", 32'(error), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vdma_rd_frame_requester.md
# vdma_rd_frame_requester

Per-channel read requester for the VDMA read path. It walks a rectangular frame buffer in DDR line by line and splits each line into bursts. It issues one burst request at a time on the req/ack/done port of a read-scheduler client slot (r*_req/r*_rstart_addr/r*_burst_size in, r*_ack/r*_done/r*_data_valid out). Bursts are only issued when the downstream line FIFO reports enough free space.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, width of byte addresses.
- BYTES_PER_BEAT, 8, bytes moved per data beat; must be a power of two.
- HRES_WIDTH, 16, width of the beats-per-line count.
- VRES_WIDTH, 16, width of the line count.

Ports:
- sys_clk_i  in  1  system clock; only clock.
- reset_i  in  1  asynchronous, active-low reset.
- frame_start_i  in  1  one-cycle pulse, start a frame; ignored unless idle.
- frame_base_addr_i  in  AXI_ADDR_WIDTH  byte address of line 0, sampled on frame_start_i.
- line_stride_i  in  AXI_ADDR_WIDTH  bytes between line starts, sampled on frame_start_i.
- hres_beats_i  in  HRES_WIDTH  beats per line (≥1), sampled on frame_start_i.
- vres_i  in  VRES_WIDTH  lines per frame (≥1), sampled on frame_start_i.
- max_burst_i  in  8  max beats per burst minus 1, sampled on frame_start_i.
- fifo_space_i  in  HRES_WIDTH  free beats in downstream FIFO.
- ack_i  in  1  one-cycle pulse, request accepted by scheduler.
- done_i  in  1  one-cycle pulse, burst complete.
- data_valid_i  in  1  one read beat delivered.
- req_o  out  1  burst request; level, held until ack_i.
- rstart_addr_o  out  AXI_ADDR_WIDTH  burst start byte address.
- burst_size_o  out  8  beats in burst minus 1.
- busy_o  out  1  high from frame_start_i accept to frame_done_o.
- line_done_o  out  1  one-cycle pulse after last burst of each line completes.
- frame_done_o  out  1  one-cycle pulse after last line completes.
- error_o  out  1  sticky beat-count error (see Configuration).

## Operation
- States: IDLE, SETUP, WAIT_SPACE, REQ, WAIT_DONE, LINE_END.
- IDLE: on frame_start_i, latch the config and the frame base, set line counter = 0, go to SETUP.
- SETUP: set the burst address to the line start and remaining = hres_beats. Go to WAIT_SPACE.
- WAIT_SPACE: compute len = min(remaining, max_burst+1). When fifo_space_i ≥ len, load rstart_addr_o and burst_size_o = len-1, then go to REQ.
- REQ: req_o = 1; rstart_addr_o and burst_size_o are held stable. On ack_i, go to WAIT_DONE.
- WAIT_DONE: on done_i, do addr += len*BYTES_PER_BEAT and remaining -= len.
  - If remaining ≠ 0, go to WAIT_SPACE; otherwise go to LINE_END.
- LINE_END: pulse line_done_o and increment the line counter.
  - If the counter equals vres, pulse frame_done_o in the same cycle and go to IDLE.
  - Otherwise advance the line start by line_stride and go to SETUP.
- Only one burst is outstanding at a time.
- ack_i and done_i arriving in the same cycle while in REQ: treat as ack followed by done and take the WAIT_DONE action directly.
- Address arithmetic is modulo 2^AXI_ADDR_WIDTH; wrap is silent.
- hres_beats_i = 0 or vres_i = 0: frame_start_i is ignored, busy_o stays 0.
- Reset mid-frame: all state is cleared to IDLE. The scheduler slot must be reset together with this block.

## Timing
- Reset values: req_o 0, rstart_addr_o 0, burst_size_o 0, busy_o 0, line_done_o 0, frame_done_o 0, error_o 0.
- All outputs are registered.
- frame_start_i at cycle N gives busy_o = 1 at N+1. req_o rises at N+3 at the earliest (SETUP, then WAIT_SPACE with enough space).
- req_o falls the cycle after ack_i is sampled.
- After done_i, the next req_o rises 2 cycles later at the earliest (WAIT_SPACE, then REQ).
- line_done_o and frame_done_o occur 1 cycle after the final done_i. busy_o falls in the cycle after frame_done_o.

## Configuration
- VDMA_RD_BEAT_CHECK_EN defined:
  - A beat counter is cleared on ack_i and increments on data_valid_i.
  - On done_i, if count ≠ burst_size_o+1, error_o is set. It stays set until reset or the next accepted frame_start_i.
- VDMA_RD_BEAT_CHECK_EN not defined: no counter; error_o is tied to 0.

## Test plan
- Frame base=0x1000, stride=0x800, hres=40, vres=2, max_burst=15, space 1024:
  - Bursts per line are 16/16/8.
  - Addresses 0x1000, 0x1080, 0x1100, then 0x1800, 0x1880, 0x1900.
  - Two line_done_o pulses, then one frame_done_o.
- fifo_space_i = 10 with len 16: req_o stays 0. Raise space to 16: req_o rises 2 cycles later.
- ack_i delayed 5 cycles: req_o and the address/size stay stable throughout; req_o falls the cycle after ack_i.
- ack_i and done_i in the same cycle on a 1-beat line: the next line's request is issued; no hang.
- reset_i low during WAIT_DONE of burst 2: all outputs are at reset values immediately. A new frame restarts at its base.
- With VDMA_RD_BEAT_CHECK_EN: burst_size 7 receives only 7 data_valid_i beats before done_i, so error_o = 1. A new frame_start_i clears it.
